// File: rtl/rtc_pkg.sv
// Shared field layout, reset constants and calendar helpers for the RTC/calendar counter.
package rtc_pkg;

  localparam int unsigned TIME_W   = 17;
  localparam int unsigned DATE_W   = 17;

  localparam int unsigned SEC_LSB  = 0;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_LSB  = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_LSB = 12;
  localparam int unsigned HOUR_W   = 4;
  localparam int unsigned MER_BIT  = 16;

  localparam int unsigned DAY_LSB  = 0;
  localparam int unsigned DAY_W    = 5;
  localparam int unsigned MON_LSB  = 5;
  localparam int unsigned MON_W    = 5;
  localparam int unsigned YEAR_LSB = 10;
  localparam int unsigned YEAR_W   = 7;

  localparam logic MER_AM = 1'b0;
  localparam logic MER_PM = 1'b1;

  typedef struct packed {
    logic              mer;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } rtc_time_t;

  typedef struct packed {
    logic [YEAR_W-1:0] year;
    logic [MON_W-1:0]  month;
    logic [DAY_W-1:0]  day;
  } rtc_date_t;

  localparam rtc_time_t TIME_RST = '{mer: MER_AM, hour: 4'd12, min: 6'd0, sec: 6'd0};
  localparam rtc_date_t DATE_RST = '{year: 7'd0, month: 5'd1, day: 5'd1};

  // Every year in 2000..2099 divisible by 4 is a leap year.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0]  month,
                                                     input logic [YEAR_W-1:0] year);
    logic [DAY_W-1:0] dim;
    case (month)
      5'd4, 5'd6, 5'd9, 5'd11: dim = 5'd30;
      5'd2:                    dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

  function automatic rtc_time_t sanitise_time(input logic [TIME_W-1:0] w);
    rtc_time_t t;
    t = rtc_time_t'(w);
    if (t.sec > 6'd59) t.sec = '0;
    if (t.min > 6'd59) t.min = '0;
    if ((t.hour == 4'd0) || (t.hour > 4'd12)) t.hour = 4'd12;
    return t;
  endfunction

  // Month and year are fixed up first so the day clamp uses legal values.
  function automatic rtc_date_t sanitise_date(input logic [DATE_W-1:0] w);
    rtc_date_t        d;
    logic [DAY_W-1:0] dim;
    d = rtc_date_t'(w);
    if (d.year > 7'd99) d.year = '0;
    if ((d.month == 5'd0) || (d.month > 5'd12)) d.month = 5'd1;
    if (d.day == 5'd0) d.day = 5'd1;
    dim = days_in_month(d.month, d.year);
    if (d.day > dim) d.day = dim;
    return d;
  endfunction

endpackage

// File: rtl/rtc_calendar_counter_if.sv
// Load/hold controls from the control stage and live time/date back to it.
interface rtc_calendar_counter_if;
  import rtc_pkg::*;

  logic              HOLD;
  logic              LOAD;
  logic [TIME_W-1:0] LOAD_TIME;
  logic [DATE_W-1:0] LOAD_DATE;
  logic [TIME_W-1:0] CUR_TIME;
  logic [DATE_W-1:0] CUR_DATE;
  logic              SEC_PULSE;
  logic              DAY_PULSE;

  modport master (
    output HOLD, LOAD, LOAD_TIME, LOAD_DATE,
    input  CUR_TIME, CUR_DATE, SEC_PULSE, DAY_PULSE
  );

  modport slave (
    input  HOLD, LOAD, LOAD_TIME, LOAD_DATE,
    output CUR_TIME, CUR_DATE, SEC_PULSE, DAY_PULSE
  );
endinterface

// File: rtl/rtc_prescaler.sv
// Divides CLK down to a one-cycle TICK per second; HOLD freezes, CLEAR restarts the count.
module rtc_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PRESCALE_W    = 26
) (
  input  logic CLK,
  input  logic RESET,
  input  logic HOLD,
  input  logic CLEAR,
  output logic TICK
);

  localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] r_count;
  logic                  w_term;

  assign w_term = (r_count == TERM);
  assign TICK   = w_term & ~HOLD & ~CLEAR & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET || CLEAR) begin
      r_count <= '0;
    end else if (!HOLD) begin
      r_count <= w_term ? '0 : r_count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/rtc_calendar_counter.sv
// Live 12-hour clock and 2000..2099 calendar: loads sanitised settings or ripples one second per tick.
module rtc_calendar_counter
  import rtc_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PRESCALE_W    = 26
) (
  input  logic                 CLK,
  input  logic                 RESET,
  rtc_calendar_counter_if.slave bus
);

  rtc_time_t        r_time;
  rtc_date_t        r_date;
  logic             r_sec_pulse;
  logic             r_day_pulse;

  logic             w_tick;
  rtc_time_t        w_next_time;
  rtc_date_t        w_next_date;
  logic             w_day_carry;
  logic [DAY_W-1:0] w_dim;

  rtc_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .PRESCALE_W    (PRESCALE_W)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .HOLD  (bus.HOLD),
    .CLEAR (bus.LOAD),
    .TICK  (w_tick)
  );

  assign w_dim = days_in_month(r_date.month, r_date.year);

  // One-second ripple: sec -> min -> hour/meridian -> day -> month -> year.
  always_comb begin
    w_next_time = r_time;
    w_next_date = r_date;
    w_day_carry = 1'b0;

    if (r_time.sec == 6'd59) begin
      w_next_time.sec = '0;
      if (r_time.min == 6'd59) begin
        w_next_time.min = '0;
        if (r_time.hour == 4'd12) begin
          w_next_time.hour = 4'd1;
        end else begin
          w_next_time.hour = r_time.hour + 4'd1;
          if (r_time.hour == 4'd11) begin
            w_next_time.mer = ~r_time.mer;
            w_day_carry     = (r_time.mer == MER_PM);
          end
        end
      end else begin
        w_next_time.min = r_time.min + 6'd1;
      end
    end else begin
      w_next_time.sec = r_time.sec + 6'd1;
    end

    if (w_day_carry) begin
      if (r_date.day == w_dim) begin
        w_next_date.day = 5'd1;
        if (r_date.month == 5'd12) begin
          w_next_date.month = 5'd1;
          w_next_date.year  = (r_date.year == 7'd99) ? 7'd0 : r_date.year + 7'd1;
        end else begin
          w_next_date.month = r_date.month + 5'd1;
        end
      end else begin
        w_next_date.day = r_date.day + 5'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_time      <= TIME_RST;
      r_date      <= DATE_RST;
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
    end else if (bus.LOAD) begin
      r_time      <= sanitise_time(bus.LOAD_TIME);
      r_date      <= sanitise_date(bus.LOAD_DATE);
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
    end else if (w_tick) begin
      r_time      <= w_next_time;
      r_date      <= w_next_date;
      r_sec_pulse <= 1'b1;
      r_day_pulse <= w_day_carry;
    end else begin
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
    end
  end

  assign bus.CUR_TIME  = r_time;
  assign bus.CUR_DATE  = r_date;
  assign bus.SEC_PULSE = r_sec_pulse;
  assign bus.DAY_PULSE = r_day_pulse;

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Directed bench: stimulus queues expected advances, a negedge monitor checks every pulse.
module tb_rtc_calendar_counter;
  import rtc_pkg::*;

  logic CLK = 1'b0;
  logic RESET;

  rtc_calendar_counter_if bus ();

  rtc_calendar_counter #(
    .TICKS_PER_SEC (4),
    .PRESCALE_W    (2)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [16:0] t;
    logic [16:0] d;
    logic        dp;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [16:0] mk_t(input bit mer, input int h, input int m, input int s);
    return {mer, 4'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [16:0] mk_d(input int y, input int mo, input int d);
    return {7'(y), 5'(mo), 5'(d)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_cur(input string name, input logic [16:0] t, input logic [16:0] d);
    chk({name, "_time"}, 32'(bus.CUR_TIME), 32'(t));
    chk({name, "_date"}, 32'(bus.CUR_DATE), 32'(d));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [16:0] t, input logic [16:0] d);
    bus.LOAD      = 1'b1;
    bus.LOAD_TIME = t;
    bus.LOAD_DATE = d;
    step(1);
    bus.LOAD      = 1'b0;
  endtask

  task automatic expect_adv(input logic [16:0] t, input logic [16:0] d, input logic dp,
                            input int dly);
    exp_t e;
    e.t   = t;
    e.d   = d;
    e.dp  = dp;
    e.cyc = cyc + dly;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expected advance, including its cycle.
  always @(negedge CLK) begin
    if ((bus.SEC_PULSE === 1'b1) || (bus.DAY_PULSE === 1'b1)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_pulse: got sec=%b day=%b at cycle %0d want no pulse",
                 bus.SEC_PULSE, bus.DAY_PULSE, cyc);
      end else begin : pop
        exp_t e;
        e = sb.pop_front();
        chk("adv_time",  32'(bus.CUR_TIME),  32'(e.t));
        chk("adv_date",  32'(bus.CUR_DATE),  32'(e.d));
        chk("sec_pulse", 32'(bus.SEC_PULSE), 32'(1));
        chk("day_pulse", 32'(bus.DAY_PULSE), 32'(e.dp));
        chk("adv_cycle", 32'(cyc),           32'(e.cyc));
      end
    end
  end

  initial begin
    RESET         = 1'b1;
    bus.HOLD      = 1'b0;
    bus.LOAD      = 1'b0;
    bus.LOAD_TIME = '0;
    bus.LOAD_DATE = '0;

    // 1) reset state and first second
    step(2);
    RESET = 1'b0;
    chk_cur("reset", mk_t(0, 12, 0, 0), mk_d(0, 1, 1));
    chk("reset_sec_pulse", 32'(bus.SEC_PULSE), 32'(0));
    chk("reset_day_pulse", 32'(bus.DAY_PULSE), 32'(0));
    expect_adv(mk_t(0, 12, 0, 1), mk_d(0, 1, 1), 1'b0, 4);
    step(4);
    step(1);
    chk("sec_pulse_single", 32'(bus.SEC_PULSE), 32'(0));

    // 2) leap February
    do_load(mk_t(1, 11, 59, 59), mk_d(24, 2, 28));
    chk_cur("load_leap", mk_t(1, 11, 59, 59), mk_d(24, 2, 28));
    expect_adv(mk_t(0, 12, 0, 0), mk_d(24, 2, 29), 1'b1, 4);
    step(4);
    step(1);
    chk("day_pulse_single", 32'(bus.DAY_PULSE), 32'(0));
    do_load(mk_t(1, 11, 59, 59), mk_d(24, 2, 29));
    expect_adv(mk_t(0, 12, 0, 0), mk_d(24, 3, 1), 1'b1, 4);
    step(4);

    // 3) non-leap February, noon, 12 -> 1
    do_load(mk_t(1, 11, 59, 59), mk_d(23, 2, 28));
    expect_adv(mk_t(0, 12, 0, 0), mk_d(23, 3, 1), 1'b1, 4);
    step(4);
    do_load(mk_t(0, 11, 59, 59), mk_d(23, 3, 1));
    expect_adv(mk_t(1, 12, 0, 0), mk_d(23, 3, 1), 1'b0, 4);
    step(4);
    do_load(mk_t(1, 12, 59, 58), mk_d(23, 3, 1));
    expect_adv(mk_t(1, 12, 59, 59), mk_d(23, 3, 1), 1'b0, 4);
    expect_adv(mk_t(1, 1, 0, 0),    mk_d(23, 3, 1), 1'b0, 8);
    step(8);

    // 4) year wrap
    do_load(mk_t(1, 11, 59, 59), mk_d(99, 12, 31));
    expect_adv(mk_t(0, 12, 0, 0), mk_d(0, 1, 1), 1'b1, 4);
    step(4);

    // 5a) HOLD at count 2 for 10 cycles, advance 2 cycles after release
    expect_adv(mk_t(0, 12, 0, 1), mk_d(0, 1, 1), 1'b0, 14);
    step(2);
    bus.HOLD = 1'b1;
    step(10);
    bus.HOLD = 1'b0;
    step(2);

    // 5b) LOAD at terminal count suppresses the tick
    step(3);
    do_load(mk_t(0, 5, 0, 0), mk_d(0, 1, 1));
    chk_cur("load_term", mk_t(0, 5, 0, 0), mk_d(0, 1, 1));
    chk("load_term_pulse", 32'(bus.SEC_PULSE), 32'(0));
    expect_adv(mk_t(0, 5, 0, 1), mk_d(0, 1, 1), 1'b0, 4);
    step(4);

    // 5c) LOAD honoured under HOLD, no advance until release
    bus.HOLD = 1'b1;
    do_load(mk_t(0, 6, 30, 0), mk_d(10, 6, 15));
    chk_cur("load_hold", mk_t(0, 6, 30, 0), mk_d(10, 6, 15));
    step(5);
    chk_cur("hold_frozen", mk_t(0, 6, 30, 0), mk_d(10, 6, 15));
    bus.HOLD = 1'b0;
    expect_adv(mk_t(0, 6, 30, 1), mk_d(10, 6, 15), 1'b0, 4);
    step(4);

    // 6) sanitising
    do_load(mk_t(0, 0, 60, 63), mk_d(120, 4, 31));
    chk_cur("san_a", mk_t(0, 12, 0, 0), mk_d(0, 4, 30));
    expect_adv(mk_t(0, 12, 0, 1), mk_d(0, 4, 30), 1'b0, 4);
    step(4);
    do_load(mk_t(1, 13, 30, 15), mk_d(5, 13, 0));
    chk_cur("san_b", mk_t(1, 12, 30, 15), mk_d(5, 1, 1));
    do_load(mk_t(0, 3, 0, 0), mk_d(1, 2, 30));
    chk_cur("san_feb", mk_t(0, 3, 0, 0), mk_d(1, 2, 28));
    do_load(mk_t(0, 3, 0, 0), mk_d(4, 2, 31));
    chk_cur("san_feb_leap", mk_t(0, 3, 0, 0), mk_d(4, 2, 29));

    // reset beats LOAD
    RESET         = 1'b1;
    bus.LOAD      = 1'b1;
    bus.LOAD_TIME = mk_t(1, 7, 7, 7);
    bus.LOAD_DATE = mk_d(50, 7, 7);
    step(1);
    RESET    = 1'b0;
    bus.LOAD = 1'b0;
    chk_cur("reset_over_load", mk_t(0, 12, 0, 0), mk_d(0, 1, 1));
    step(3);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
